// File: rtl/cordic_sum_sequencer.sv
// Feeder and result collector for the CORDIC-plus-add unit. Samples are
// queued in a small FIFO and folded one at a time into a running sum. When
// the sample marked "last" retires, the sum is offered on an output handshake.
module cordic_sum_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int CW         = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        op_start,
    output logic [31:0] op_dataa,
    output logic [31:0] op_datab,
    input  logic [31:0] op_result,
    input  logic        op_done,
    output logic        sum_valid,
    output logic [31:0] sum_data,
    input  logic        sum_ready,
    output logic        busy,
    output logic        err,
    input  logic        clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_nextState;

    logic [32:0]   r_fifoMem [FIFO_DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic [32:0]   w_head;

    logic [31:0]   r_sum;
    logic [31:0]   r_opA;
    logic [31:0]   r_opB;
    logic          r_last;
    logic          r_err;
    logic [CW-1:0] r_timer;
    logic          w_retire;
    logic          w_timeout;

    // The extra pointer bit separates the full case from the empty case.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
    assign w_head  = r_fifoMem[r_rdPtr[AW-1:0]];

    // s_ready is also gated by reset, so every output reads 0 while reset is held.
    assign s_ready = reset_n && !w_full && (r_state != ST_ERR);
    assign w_push  = s_valid && s_ready;
    assign w_pop   = (r_state == ST_ISSUE);
    assign w_flush = (r_state == ST_ERR);

    // A done seen while the timer is still 0 can be stale from the previous
    // operation, so it is ignored. ERR is entered TIMEOUT cycles after
    // op_start: the ISSUE cycle plus TIMEOUT-1 WAIT cycles.
    assign w_retire  = (r_state == ST_WAIT) && op_done && (r_timer != '0);
    assign w_timeout = (r_state == ST_WAIT) && !w_retire && (r_timer == CW'(TIMEOUT - 2));

    // Sample storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr[AW-1:0]] <= {s_last, s_data};
        end
    end

    // Pointers advance on push and pop; ERR discards everything queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_flush) begin
                r_rdPtr <= r_wrPtr;
            end else if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    // Next-state selection for the issue / wait / output sequence.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_retire) begin
                    if (r_last) begin
                        w_nextState = ST_OUT;
                    end else if (!w_empty) begin
                        w_nextState = ST_ISSUE;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_nextState = ST_ERR;
                end
            end
            ST_OUT: begin
                if (sum_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operands and the last flag are captured at issue and held for the unit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opA  <= '0;
            r_opB  <= '0;
            r_last <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            r_opA  <= w_head[31:0];
            r_opB  <= r_sum;
            r_last <= w_head[32];
        end
    end

    // Per-operation timer: cleared at issue, counts every WAIT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_timer <= '0;
        end else if (r_state == ST_WAIT) begin
            r_timer <= r_timer + CW'(1);
        end
    end

    // Running sum: takes each retired result, cleared after output or in ERR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (w_retire) begin
            r_sum <= op_result;
        end else if ((r_state == ST_OUT) && sum_ready) begin
            r_sum <= '0;
        end else if (r_state == ST_ERR) begin
            r_sum <= '0;
        end
    end

    // Sticky error flag; only clr_err while in ERR releases it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_ERR) && clr_err) begin
            r_err <= 1'b0;
        end
    end

    // During ISSUE the operands come straight from the FIFO head and the sum.
    assign op_start  = (r_state == ST_ISSUE);
    assign op_dataa  = op_start ? w_head[31:0] : r_opA;
    assign op_datab  = op_start ? r_sum : r_opB;
    assign sum_valid = (r_state == ST_OUT);
    assign sum_data  = sum_valid ? r_sum : '0;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign err       = r_err;

endmodule
